// File: rtl/voice_sequencer.sv
// Time-multiplexes the shared voice datapath: once per sample tick, walks every
// voice through a READ/STEP pair and hands the datapath one step command per voice.
module voice_sequencer #(
    parameter int NUM_VOICES    = 4,
    parameter int VOICE_BITS    = 2,
    parameter int PERIOD_BITS   = 14,
    parameter int SAMPLE_PERIOD = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   cfg_we,
    input  logic [VOICE_BITS-1:0]  cfg_voice,
    input  logic [PERIOD_BITS-1:0] cfg_period,
    output logic                   cfg_ready,
    output logic                   dp_valid,
    output logic [VOICE_BITS-1:0]  dp_voice,
    output logic [PERIOD_BITS-1:0] dp_period,
    output logic                   dp_oct_en,
    output logic                   sample_done,
    output logic                   overrun
);

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [VOICE_BITS-1:0] V_LAST = VOICE_BITS'(NUM_VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_STEP, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [TW-1:0]          r_timer;
    logic [15:0]            r_oct, r_oct_cap;
    logic [VOICE_BITS-1:0]  r_v, w_rd_idx;
    logic [PERIOD_BITS-1:0] r_lat;
    logic [PERIOD_BITS-1:0] r_period [NUM_VOICES];

    logic                   w_tick, w_accept, w_last_v, w_cfg_wr;
    logic [3:0]             w_exp;
    logic [15:0]            w_oct_mask;
    logic                   w_dp_valid, w_dp_oct_en, w_done;
    logic [VOICE_BITS-1:0]  w_dp_voice;
    logic [PERIOD_BITS-1:0] w_dp_period;

    assign w_tick    = en && (r_timer == T_LAST);
    assign w_accept  = w_tick && (r_state == S_IDLE);
    assign w_last_v  = (r_v == V_LAST);
    assign cfg_ready = (r_state != S_READ);
    assign w_cfg_wr  = cfg_we && cfg_ready && (int'(cfg_voice) < NUM_VOICES);
    // Next voice to fetch: voice 0 when leaving IDLE, otherwise the one after r_v.
    assign w_rd_idx  = (r_state == S_IDLE) ? '0 : r_v + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_tick) w_state_nxt = S_READ;
            S_READ: w_state_nxt = S_STEP;
            S_STEP: w_state_nxt = w_last_v ? S_DONE : S_READ;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered and registered below.
    always_comb begin
        w_exp       = r_lat[PERIOD_BITS-1 -: 4];
        w_oct_mask  = (16'd1 << w_exp) - 16'd1;
        w_dp_valid  = (w_state_nxt == S_STEP);
        w_dp_voice  = '0;
        w_dp_period = '0;
        w_dp_oct_en = 1'b0;
        w_done      = (w_state_nxt == S_DONE);
        if (w_dp_valid) begin
            w_dp_voice  = r_v;
            w_dp_period = r_lat;
            w_dp_oct_en = ((r_oct_cap & w_oct_mask) == 16'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid    <= 1'b0;
            dp_voice    <= '0;
            dp_period   <= '0;
            dp_oct_en   <= 1'b0;
            sample_done <= 1'b0;
        end else begin
            dp_valid    <= w_dp_valid;
            dp_voice    <= w_dp_voice;
            dp_period   <= w_dp_period;
            dp_oct_en   <= w_dp_oct_en;
            sample_done <= w_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_oct     <= '0;
            r_oct_cap <= '0;
            overrun   <= 1'b0;
        end else begin
            if (en) r_timer <= (r_timer == T_LAST) ? '0 : r_timer + 1'b1;
            if (w_accept) begin
                r_oct_cap <= r_oct;
                r_oct     <= r_oct + 16'd1;
            end
            if (w_tick && r_state != S_IDLE) overrun <= 1'b1;
        end
    end

    // The period is snapshotted on entry to READ, so a write landing on the
    // same edge only shows up from the next sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_lat <= '0;
        end else begin
            if (w_accept) r_v <= '0;
            else if (r_state == S_STEP && !w_last_v) r_v <= r_v + 1'b1;
            if (w_state_nxt == S_READ) r_lat <= r_period[w_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) r_period[i] <= '0;
        end else if (w_cfg_wr) begin
            r_period[cfg_voice] <= cfg_period;
        end
    end

endmodule

// File: tb/tb_voice_sequencer.sv
// Random-stimulus bench for voice_sequencer: two instances (64- and 6-cycle sample
// periods) share inputs, each checked every cycle against a sequence-position model.
module tb_voice_sequencer;
    localparam int NV = 4;
    localparam int VB = 2;
    localparam int PB = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic cfg_we = 1'b0;
    logic [VB-1:0] cfg_voice = '0;
    logic [PB-1:0] cfg_period = '0;

    logic [1:0]         rdy, vld, oen, done, ovr;
    logic [1:0][VB-1:0] voice;
    logic [1:0][PB-1:0] per;

    voice_sequencer #(.NUM_VOICES(NV), .VOICE_BITS(VB), .PERIOD_BITS(PB), .SAMPLE_PERIOD(64)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_voice(cfg_voice),
        .cfg_period(cfg_period), .cfg_ready(rdy[0]), .dp_valid(vld[0]), .dp_voice(voice[0]),
        .dp_period(per[0]), .dp_oct_en(oen[0]), .sample_done(done[0]), .overrun(ovr[0]));

    voice_sequencer #(.NUM_VOICES(NV), .VOICE_BITS(VB), .PERIOD_BITS(PB), .SAMPLE_PERIOD(6)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_voice(cfg_voice),
        .cfg_period(cfg_period), .cfg_ready(rdy[1]), .dp_valid(vld[1]), .dp_voice(voice[1]),
        .dp_period(per[1]), .dp_oct_en(oen[1]), .sample_done(done[1]), .overrun(ovr[1]));

    always #5 clk = ~clk;

    // Model: m_p is the position within a sample sequence (0 = idle, 1 = first
    // READ, even = STEP of voice p/2-1, 2*NV+1 = DONE).
    int            m_p [2];
    int            m_timer [2];
    int            m_oct [2];
    int            m_cap [2];
    logic [PB-1:0] m_lat [2];
    logic [PB-1:0] m_per [2][NV];
    bit            m_ovr [2];

    int total = 0;
    int bad = 0;
    bit en_ctl = 1'b0;
    int wprob = 0;
    int f_cnt = 0;
    logic [VB-1:0] f_v = '0;
    logic [PB-1:0] f_d = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sp(input int k);
        return (k == 0) ? 64 : 6;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_p[k] = 0; m_timer[k] = 0; m_oct[k] = 0; m_cap[k] = 0;
            m_lat[k] = '0; m_ovr[k] = 1'b0;
            for (int v = 0; v < NV; v++) m_per[k][v] = '0;
        end
    endtask

    task automatic check_adv();
        for (int k = 0; k < 2; k++) begin
            int  p = m_p[k];
            bit  step = (p >= 2) && (p <= 2*NV) && (p % 2 == 0);
            bit  ready = !((p % 2 == 1) && (p <= 2*NV - 1));
            bit  tick = en && (m_timer[k] == sp(k) - 1);
            int  e = int'(m_lat[k][13:10]);
            int  exp_v = step ? (p/2 - 1) : 0;
            int  exp_per = step ? int'(m_lat[k]) : 0;
            int  exp_oe = (step && (m_cap[k] % (1 << e)) == 0) ? 1 : 0;
            chk($sformatf("d%0d_valid", k), 32'(vld[k]), 32'(step));
            chk($sformatf("d%0d_voice", k), 32'(voice[k]), 32'(exp_v));
            chk($sformatf("d%0d_period", k), 32'(per[k]), 32'(exp_per));
            chk($sformatf("d%0d_oct_en", k), 32'(oen[k]), 32'(exp_oe));
            chk($sformatf("d%0d_done", k), 32'(done[k]), 32'(p == 2*NV + 1));
            chk($sformatf("d%0d_ready", k), 32'(rdy[k]), 32'(ready));
            chk($sformatf("d%0d_overrun", k), 32'(ovr[k]), 32'(m_ovr[k]));
            if (p == 0 && tick) m_lat[k] = m_per[k][0];
            else if (step && p <= 2*NV - 2) m_lat[k] = m_per[k][p/2];
            if (cfg_we && ready && int'(cfg_voice) < NV) m_per[k][cfg_voice] = cfg_period;
            if (tick && p != 0) m_ovr[k] = 1'b1;
            if (p == 0 && tick) begin
                m_cap[k] = m_oct[k];
                m_oct[k] = (m_oct[k] + 1) % 65536;
            end
            if (en) m_timer[k] = (m_timer[k] + 1) % sp(k);
            if (p == 0) m_p[k] = tick ? 1 : 0;
            else        m_p[k] = (p == 2*NV + 1) ? 0 : p + 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        en = en_ctl;
        if (f_cnt > 0) begin
            cfg_we = 1'b1; cfg_voice = f_v; cfg_period = f_d; f_cnt--;
        end else if (wprob > 0 && $urandom_range(0, 99) < wprob) begin
            cfg_we = 1'b1;
            cfg_voice = VB'($urandom_range(0, NV - 1));
            cfg_period = PB'($urandom());
        end else begin
            cfg_we = 1'b0;
        end
        @(negedge clk);
        check_adv();
    endtask

    task automatic do_reset(input bit mid_step);
        @(posedge clk);
        #1;
        if (mid_step) chk("pre_rst_valid", 32'(vld[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        cfg_we = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_valid", k), 32'(vld[k]), 32'd0);
            chk($sformatf("rst%0d_done", k), 32'(done[k]), 32'd0);
            chk($sformatf("rst%0d_overrun", k), 32'(ovr[k]), 32'd0);
            chk($sformatf("rst%0d_ready", k), 32'(rdy[k]), 32'd1);
        end
        model_reset();
        @(posedge clk);
        #2;
        en = en_ctl;
        rst_n = 1'b1;
        @(negedge clk);
        check_adv();
    endtask

    task automatic wait_p(input int target, input string tag);
        int n = 0;
        while (m_p[0] != target && n < 500) begin
            cycle();
            n++;
        end
        chk(tag, 32'(n < 500), 32'd1);
    endtask

    initial begin
        int cnt_v2 = 0;
        model_reset();
        #3;
        chk("init_valid", 32'(vld[0]), 32'd0);
        chk("init_ready", 32'(rdy[0]), 32'd1);
        en_ctl = 1'b1;
        @(posedge clk);
        #2;
        en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check_adv();

        // All periods zero: every voice steps with oct_en each tick.
        repeat (200) cycle();

        // Voice 2 at exponent 3: oct_en on oct 0 and 8 over 16 ticks.
        do_reset(1'b0);
        f_v = 2'd2; f_d = 14'h0C00; f_cnt = 1;
        repeat (16*64 + 20) begin
            cycle();
            if (vld[0] && voice[0] == 2'd2 && oen[0]) cnt_v2++;
        end
        chk("v2_octen_cnt", 32'(cnt_v2), 32'd2);

        // Write held across READ of voice 1: one stall cycle, old value this sample.
        wait_p(2, "wait_step0");
        f_v = 2'd1; f_d = 14'h0123; f_cnt = 2;
        cycle();
        cycle();
        chk("held_ready_read", 32'(rdy[0]), 32'd0);
        repeat (140) cycle();

        // Enable dropped mid-sequence: sequence finishes, timer freezes.
        wait_p(3, "wait_read1");
        en_ctl = 1'b0;
        repeat (200) cycle();
        en_ctl = 1'b1;
        repeat (100) cycle();

        // Random writes and enable toggles.
        wprob = 10;
        repeat (3000) begin
            if ($urandom_range(0, 99) < 3) en_ctl = ~en_ctl;
            cycle();
        end
        en_ctl = 1'b1;

        // Asynchronous reset during STEP of voice 1.
        wait_p(4, "wait_step1");
        do_reset(1'b1);
        wprob = 0;
        repeat (150) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
